mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Sequencer and arbiter for the shared 10-bit multiplexed memory bus (`addr_data`, `read_write`, `write_commit`). It accepts independent fetch, load and store requests from the pipeline, grants one at a time, and runs each through a fixed multi-cycle bus protocol. It also drives the halt signature onto the bus. It sits between the pipeline control logic and the top-level memory pins, replacing ad-hoc per-stage bus muxing.

## Interface
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations after which fetch gets top priority once. Range 1..15. Only used with `MEM_ARB_STARVE_EN`.

- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: fetch request; held until `fetch_gnt`.
- `fetch_addr` in 10: fetch address.
- `ld_req` in 1: load request; held until `ld_gnt`.
- `ld_addr` in 10: load address.
- `st_req` in 1: store request; held until `st_gnt`.
- `st_addr` in 10: store address.
- `st_data` in 6: store data.
- `st_upper` in 1: STOREU; sets bus bit 6 in the data phase.
- `halt_req` in 1: level; committed instruction is HALT.
- `mem_result` in 12: read data from memory.
- `fetch_gnt` / `ld_gnt` / `st_gnt` out 1 each: one-cycle grant pulses.
- `fetch_valid` / `ld_valid` out 1 each: one-cycle read-data-valid pulses.
- `rd_data` out 12: registered read data; qualified by a `*_valid` pulse.
- `st_done` out 1: one-cycle store-complete pulse.
- `mem_bus_out` out 10: drives `addr_data[9:0]`.
- `mem_read_write` out 1: 1 = read, 0 = write.
- `write_commit` out 1: write data phase, or halt signature.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ADDR: address phase.
  - RD_CAP: read capture.
  - WR_DATA: write data phase.
  - HALTED: terminal.
- Arbitration happens in IDLE only, on each edge.
  - Priority: halt_req > st_req > ld_req > fetch_req.
  - The winner's address, data and `st_upper` are latched at that edge. State goes to ADDR, or to HALTED for halt.
  - The matching `*_gnt` is high for exactly the ADDR cycle.
- ADDR:
  - Bus carries the latched address.
  - `mem_read_write` = 0 for a store, 1 otherwise.
  - `write_commit` = 0.
  - Next state: WR_DATA for a store, RD_CAP otherwise.
- RD_CAP:
  - Address is held on the bus with `mem_read_write` = 1.
  - `mem_result` is sampled into `rd_data` at the end of the cycle.
  - Next state: IDLE.
- WR_DATA:
  - Bus = {3'b000, st_upper, st_data}.
  - `mem_read_write` = 0, `write_commit` = 1.
  - Next state: IDLE.
- Completion:
  - The cycle after RD_CAP, `fetch_valid` or `ld_valid` pulses with `rd_data`.
  - The cycle after WR_DATA, `st_done` pulses.
  - IDLE arbitrates in that same cycle, so back-to-back transactions are allowed.
- HALTED:
  - Bus = 0, `mem_read_write` = 1, `write_commit` = 1.
  - Sticky until reset. All later requests are ignored and no grants are issued.
- Request behaviour outside IDLE:
  - `halt_req` asserted mid-transaction waits; the transaction completes first.
  - A request dropped after its grant does not abort the transaction.
  - A request deasserted before grant is simply lost. This is legal.
- IDLE bus value: `mem_bus_out` = 0, `mem_read_write` = 1, `write_commit` = 0.

## Timing
- Read: request seen at edge 0. `gnt` in cycle 1 (ADDR). Cycle 2 is RD_CAP. `valid` + data in cycle 3. Latency is 3 cycles from the arbitration cycle.
- Store: `gnt` in cycle 1, data phase in cycle 2, `st_done` in cycle 3.
- Peak throughput: one transaction per 2 bus cycles plus 1 arbitration cycle, overlapping with completion.
- All outputs are registered or decoded from the registered state only. There are no combinational paths from request inputs to outputs.
- Reset values, applied immediately on `rst_n` low regardless of clock:
  - State = IDLE.
  - `mem_bus_out` = 0, `mem_read_write` = 1, `write_commit` = 0.
  - All `gnt`/`valid`/`done` = 0, `rd_data` = 0, `busy` = 0, starvation counter = 0.
- Reset mid-transaction abandons it. No completion pulse is issued after release.

## Configuration
- `MEM_ARB_STARVE_EN` defined: a 4-bit starvation counter is built.
  - It increments on each IDLE arbitration where `fetch_req` is high and fetch loses, saturating at 15.
  - It clears on a fetch grant.
  - When the counter ≥ `STARVE_LIMIT`, fetch outranks load and store, but not halt.
- `MEM_ARB_STARVE_EN` undefined: strict fixed priority, no counter logic.

## Test plan
- Single fetch, addr 0x155, `mem_result` 0xA3C in RD_CAP → `fetch_gnt` in cycle 1, `fetch_valid` and `rd_data` = 0xA3C in cycle 3. Bus shows 0x155, rw = 1 in cycles 1–2.
- Store, addr 0x2F0, data 0x2A, `st_upper` = 1 → cycle 1: bus 0x2F0, rw = 0, wc = 0. Cycle 2: bus 0x06A, rw = 0, wc = 1. `st_done` in cycle 3.
- Simultaneous st, ld and fetch requests held → grant order is st, ld, fetch, with each next grant in the completion cycle of the previous transaction.
- With `MEM_ARB_STARVE_EN`, `STARVE_LIMIT` = 2, and ld_req plus fetch_req held → sequence is ld, ld, fetch, ld, ld, fetch. Without the macro, fetch is never granted.
- `halt_req` raised during a load's ADDR cycle → load completes (`ld_valid`), then HALTED: bus 0, rw = 1, wc = 1. Later requests get no grant.
- `rst_n` pulsed low during WR_DATA → outputs go to reset values immediately. No `st_done` is issued, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Sequencer and arbiter for the shared 10-bit multiplexed memory bus. It
// accepts fetch, load and store requests from the pipeline, grants one at a
// time, and runs each one through a fixed multi-cycle bus protocol:
//   read : IDLE(arbitrate) -> ADDR -> RD_CAP -> IDLE (valid pulse)
//   write: IDLE(arbitrate) -> ADDR -> WR_DATA -> IDLE (done pulse)
// A committed HALT moves the block into a sticky HALTED state. In that state
// the halt signature (bus 0, rw 1, wc 1) is driven onto the bus.
//
// Arbitration priority: halt_req > st_req > ld_req > fetch_req.
//
// Optional feature macro: MEM_ARB_STARVE_EN
//   Defined  : a 4-bit starvation counter lets fetch outrank load/store once
//              fetch has lost STARVE_LIMIT arbitrations in a row.
//   Undefined: strict fixed priority.
//
// Parameters:
//   STARVE_LIMIT   lost arbitrations before fetch is boosted (1..15)
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   fetch_req/fetch_addr          fetch request (held until fetch_gnt)
//   ld_req/ld_addr                load request (held until ld_gnt)
//   st_req/st_addr/st_data/st_upper  store request (held until st_gnt)
//   halt_req                      level, committed instruction is HALT
//   mem_result                    read data from memory
//   fetch_gnt/ld_gnt/st_gnt       one-cycle grant pulses (ADDR cycle)
//   fetch_valid/ld_valid          one-cycle read-data-valid pulses
//   rd_data                       registered read data
//   st_done                       one-cycle store-complete pulse
//   mem_bus_out                   addr_data[9:0]
//   mem_read_write                1 = read, 0 = write
//   write_commit                  write data phase or halt signature
//   busy                          high in any state other than IDLE
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [9:0]  fetch_addr,
    input  logic        ld_req,
    input  logic [9:0]  ld_addr,
    input  logic        st_req,
    input  logic [9:0]  st_addr,
    input  logic [5:0]  st_data,
    input  logic        st_upper,
    input  logic        halt_req,
    input  logic [11:0] mem_result,
    output logic        fetch_gnt,
    output logic        ld_gnt,
    output logic        st_gnt,
    output logic        fetch_valid,
    output logic        ld_valid,
    output logic [11:0] rd_data,
    output logic        st_done,
    output logic [9:0]  mem_bus_out,
    output logic        mem_read_write,
    output logic        write_commit,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        RD_CAP  = 3'd2,
        WR_DATA = 3'd3,
        HALTED  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_FETCH = 2'd0,
        SRC_LD    = 2'd1,
        SRC_ST    = 2'd2
    } src_t;

    state_t      state_r;
    src_t        src_r;
    logic [9:0]  addr_r;
    logic [5:0]  data_r;
    logic        upper_r;

    logic        fetch_gnt_r;
    logic        ld_gnt_r;
    logic        st_gnt_r;
    logic        fetch_valid_r;
    logic        ld_valid_r;
    logic        st_done_r;
    logic [11:0] rd_data_r;
    logic [9:0]  bus_r;
    logic        rw_r;
    logic        wc_r;

    logic        fetch_boost_s;
    logic        win_halt_s;
    logic        win_st_s;
    logic        win_ld_s;
    logic        win_fetch_s;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIMIT_W = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_r;

    // Starvation counter: counts IDLE arbitrations that fetch loses to load/store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
        end else if (state_r == IDLE) begin
            if (win_fetch_s) begin
                starve_cnt_r <= 4'd0;
            end else if (fetch_req && (win_st_s || win_ld_s) && (starve_cnt_r != 4'd15)) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign fetch_boost_s = fetch_req && (starve_cnt_r >= STARVE_LIMIT_W);
`else
    assign fetch_boost_s = 1'b0;
`endif

    // Arbitration decode. It feeds only registers, so requests never reach outputs combinationally.
    always_comb begin
        win_halt_s  = 1'b0;
        win_st_s    = 1'b0;
        win_ld_s    = 1'b0;
        win_fetch_s = 1'b0;
        if (halt_req) begin
            win_halt_s = 1'b1;
        end else if (fetch_boost_s) begin
            win_fetch_s = 1'b1;
        end else if (st_req) begin
            win_st_s = 1'b1;
        end else if (ld_req) begin
            win_ld_s = 1'b1;
        end else if (fetch_req) begin
            win_fetch_s = 1'b1;
        end else begin
            win_fetch_s = 1'b0;
        end
    end

    // Bus FSM. Each branch registers the outputs belonging to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            src_r         <= SRC_FETCH;
            addr_r        <= 10'd0;
            data_r        <= 6'd0;
            upper_r       <= 1'b0;
            fetch_gnt_r   <= 1'b0;
            ld_gnt_r      <= 1'b0;
            st_gnt_r      <= 1'b0;
            fetch_valid_r <= 1'b0;
            ld_valid_r    <= 1'b0;
            st_done_r     <= 1'b0;
            rd_data_r     <= 12'd0;
            bus_r         <= 10'd0;
            rw_r          <= 1'b1;
            wc_r          <= 1'b0;
        end else begin
            // Pulses default low; a branch raises one for exactly one cycle.
            fetch_gnt_r   <= 1'b0;
            ld_gnt_r      <= 1'b0;
            st_gnt_r      <= 1'b0;
            fetch_valid_r <= 1'b0;
            ld_valid_r    <= 1'b0;
            st_done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_halt_s) begin
                        state_r <= HALTED;
                        bus_r   <= 10'd0;
                        rw_r    <= 1'b1;
                        wc_r    <= 1'b1;
                    end else if (win_st_s) begin
                        state_r  <= ADDR;
                        src_r    <= SRC_ST;
                        addr_r   <= st_addr;
                        data_r   <= st_data;
                        upper_r  <= st_upper;
                        st_gnt_r <= 1'b1;
                        bus_r    <= st_addr;
                        rw_r     <= 1'b0;
                        wc_r     <= 1'b0;
                    end else if (win_ld_s) begin
                        state_r  <= ADDR;
                        src_r    <= SRC_LD;
                        addr_r   <= ld_addr;
                        ld_gnt_r <= 1'b1;
                        bus_r    <= ld_addr;
                        rw_r     <= 1'b1;
                        wc_r     <= 1'b0;
                    end else if (win_fetch_s) begin
                        state_r     <= ADDR;
                        src_r       <= SRC_FETCH;
                        addr_r      <= fetch_addr;
                        fetch_gnt_r <= 1'b1;
                        bus_r       <= fetch_addr;
                        rw_r        <= 1'b1;
                        wc_r        <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        bus_r   <= 10'd0;
                        rw_r    <= 1'b1;
                        wc_r    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (src_r == SRC_ST) begin
                        state_r <= WR_DATA;
                        bus_r   <= {3'b000, upper_r, data_r};
                        rw_r    <= 1'b0;
                        wc_r    <= 1'b1;
                    end else begin
                        state_r <= RD_CAP;
                        bus_r   <= addr_r;
                        rw_r    <= 1'b1;
                        wc_r    <= 1'b0;
                    end
                end
                RD_CAP: begin
                    state_r   <= IDLE;
                    rd_data_r <= mem_result;
                    if (src_r == SRC_FETCH) begin
                        fetch_valid_r <= 1'b1;
                    end else begin
                        ld_valid_r <= 1'b1;
                    end
                    bus_r <= 10'd0;
                    rw_r  <= 1'b1;
                    wc_r  <= 1'b0;
                end
                WR_DATA: begin
                    state_r   <= IDLE;
                    st_done_r <= 1'b1;
                    bus_r     <= 10'd0;
                    rw_r      <= 1'b1;
                    wc_r      <= 1'b0;
                end
                HALTED: begin
                    state_r <= HALTED;
                    bus_r   <= 10'd0;
                    rw_r    <= 1'b1;
                    wc_r    <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    bus_r   <= 10'd0;
                    rw_r    <= 1'b1;
                    wc_r    <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_gnt      = fetch_gnt_r;
    assign ld_gnt         = ld_gnt_r;
    assign st_gnt         = st_gnt_r;
    assign fetch_valid    = fetch_valid_r;
    assign ld_valid       = ld_valid_r;
    assign st_done        = st_done_r;
    assign rd_data        = rd_data_r;
    assign mem_bus_out    = bus_r;
    assign mem_read_write = rw_r;
    assign write_commit   = wc_r;
    assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter: a directed cycle table, hand
// sequences for contention, starvation, halt and mid-transaction reset, and
// a randomized run against a transaction-level schedule model.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int LIMIT = 2;
`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    localparam int NRAND = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [9:0]  fetch_addr = 10'd0;
    logic        ld_req = 1'b0;
    logic [9:0]  ld_addr = 10'd0;
    logic        st_req = 1'b0;
    logic [9:0]  st_addr = 10'd0;
    logic [5:0]  st_data = 6'd0;
    logic        st_upper = 1'b0;
    logic        halt_req = 1'b0;
    logic [11:0] mem_result = 12'd0;
    logic        fetch_gnt, ld_gnt, st_gnt, fetch_valid, ld_valid, st_done;
    logic [11:0] rd_data;
    logic [9:0]  mem_bus_out;
    logic        mem_read_write, write_commit, busy;

    int n_chk = 0;
    int n_fail = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .ld_req(ld_req), .ld_addr(ld_addr),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_upper(st_upper),
        .halt_req(halt_req), .mem_result(mem_result),
        .fetch_gnt(fetch_gnt), .ld_gnt(ld_gnt), .st_gnt(st_gnt),
        .fetch_valid(fetch_valid), .ld_valid(ld_valid),
        .rd_data(rd_data), .st_done(st_done),
        .mem_bus_out(mem_bus_out), .mem_read_write(mem_read_write),
        .write_commit(write_commit), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output bundle: {fg, lg, sg, fv, lv, sd, busy, rw, wc, bus[9:0]}
    logic [18:0] dut_v;
    assign dut_v = {fetch_gnt, ld_gnt, st_gnt, fetch_valid, ld_valid, st_done,
                    busy, mem_read_write, write_commit, mem_bus_out};

    function automatic logic [18:0] ev(input logic fg, input logic lg, input logic sg,
                                       input logic fv, input logic lv, input logic sd,
                                       input logic bz, input logic rw, input logic wc,
                                       input logic [9:0] bus);
        return {fg, lg, sg, fv, lv, sd, bz, rw, wc, bus};
    endfunction

    localparam logic [18:0] V_IDLE = {9'b0000_0001_0, 10'd0};
    localparam logic [18:0] V_HALT = {9'b0000_0011_1, 10'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; halt_req = 1'b0;
        fetch_addr = 10'd0; ld_addr = 10'd0; st_addr = 10'd0;
        st_data = 6'd0; st_upper = 1'b0; mem_result = 12'd0;
    endtask

    // Reset between sequences; outputs are checked while rst_n is low.
    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'(dut_v), 32'(V_IDLE));
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        f_req;
        logic [9:0]  f_addr;
        logic        l_req;
        logic [9:0]  l_addr;
        logic        s_req;
        logic [9:0]  s_addr;
        logic [5:0]  s_data;
        logic        s_up;
        logic [11:0] mres;
        logic [18:0] exp_v;
        logic [11:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic fr, input logic [9:0] fa, input logic lr,
                                input logic [9:0] la, input logic sr, input logic [9:0] sa,
                                input logic [5:0] sdt, input logic su, input logic [11:0] mr,
                                input logic [18:0] e, input logic [11:0] erd);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_addr = la;
        v.s_req = sr; v.s_addr = sa; v.s_data = sdt; v.s_up = su;
        v.mres = mr; v.exp_v = e; v.exp_rd = erd;
        return v;
    endfunction

    vec_t tbl[15];

    // Random-run schedule model: expected bundle per cycle plus capture marks.
    logic [18:0] exp_sched [0:NRAND+3];
    bit          cap_sched [0:NRAND+3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- directed table ----------------
        tbl[0]  = mk(1'b1, 10'h155, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000, V_IDLE, 12'h000);
        tbl[1]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h155), 12'h000);
        tbl[2]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'hA3C,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h155), 12'h000);
        tbl[3]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h2F0, 6'h2A, 1'b1, 12'h000,
                     ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,10'h000), 12'hA3C);
        tbl[4]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,10'h2F0), 12'hA3C);
        tbl[5]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,10'h06A), 12'hA3C);
        tbl[6]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,10'h000), 12'hA3C);
        tbl[7]  = mk(1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000, V_IDLE, 12'hA3C);
        tbl[8]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h3FF), 12'hA3C);
        tbl[9]  = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'hFFF,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h3FF), 12'hA3C);
        tbl[10] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,10'h000), 12'hFFF);
        tbl[11] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h000, 6'h3F, 1'b0, 12'h000, V_IDLE, 12'hFFF);
        tbl[12] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,10'h000), 12'hFFF);
        tbl[13] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,10'h03F), 12'hFFF);
        tbl[14] = mk(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 12'h000,
                     ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,10'h000), 12'hFFF);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            fetch_req = tbl[i].f_req; fetch_addr = tbl[i].f_addr;
            ld_req = tbl[i].l_req; ld_addr = tbl[i].l_addr;
            st_req = tbl[i].s_req; st_addr = tbl[i].s_addr;
            st_data = tbl[i].s_data; st_upper = tbl[i].s_up;
            mem_result = tbl[i].mres;
            @(negedge clk);
            chk($sformatf("table_row%0d_bus", i), 32'(dut_v), 32'(tbl[i].exp_v));
            chk($sformatf("table_row%0d_rd", i), 32'(rd_data), 32'(tbl[i].exp_rd));
        end

        // ---------------- simultaneous st/ld/fetch ----------------
        begin
            int t_st, t_ld, t_f;
            t_st = -1; t_ld = -1; t_f = -1;
            do_reset();
            @(posedge clk);
            #1;
            st_req = 1'b1; ld_req = 1'b1; fetch_req = 1'b1;
            st_addr = 10'h011; ld_addr = 10'h022; fetch_addr = 10'h033;
            for (int cyc = 0; cyc < 15; cyc++) begin
                @(negedge clk);
                if (st_gnt && t_st < 0) begin t_st = cyc; st_req = 1'b0; end
                if (ld_gnt && t_ld < 0) begin t_ld = cyc; ld_req = 1'b0; end
                if (fetch_gnt && t_f < 0) begin t_f = cyc; fetch_req = 1'b0; end
            end
            chk("contend_st_gnt_cycle", 32'(t_st), 32'd1);
            chk("contend_ld_gnt_cycle", 32'(t_ld), 32'd4);
            chk("contend_fetch_gnt_cycle", 32'(t_f), 32'd7);
        end

        // ---------------- starvation ----------------
        begin
            byte got[6];
            byte want[6];
            int ng, nf;
            ng = 0; nf = 0;
            for (int i = 0; i < 6; i++) begin
                got[i] = 8'd0;
                want[i] = (STARVE_EN && (i % 3 == 2)) ? 8'h46 : 8'h4C;
            end
            do_reset();
            @(posedge clk);
            #1;
            ld_req = 1'b1; fetch_req = 1'b1;
            for (int cyc = 0; cyc < 30; cyc++) begin
                @(negedge clk);
                if (ld_gnt && ng < 6) begin got[ng] = 8'h4C; ng++; end
                if (fetch_gnt) begin
                    nf++;
                    if (ng < 6) begin got[ng] = 8'h46; ng++; end
                end
            end
            for (int i = 0; i < 6; i++)
                chk($sformatf("starve_grant%0d", i), 32'(got[i]), 32'(want[i]));
            chk("starve_fetch_grants", 32'(nf), STARVE_EN ? 32'd3 : 32'd0);
            clear_inputs();
        end

        // ---------------- halt during load ADDR ----------------
        do_reset();
        @(posedge clk);
        #1;
        ld_req = 1'b1; ld_addr = 10'h0AA;
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic [18:0] e;
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (cyc == 1) begin ld_req = 1'b0; halt_req = 1'b1; end
            mem_result = (cyc == 2) ? 12'h123 : 12'h000;
            if (cyc >= 5) begin fetch_req = 1'b1; ld_req = 1'b1; st_req = 1'b1; end
            @(negedge clk);
            case (cyc)
                0: e = V_IDLE;
                1: e = ev(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h0AA);
                2: e = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,10'h0AA);
                3: e = ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,10'h000);
                default: e = V_HALT;
            endcase
            chk($sformatf("halt_cyc%0d", cyc), 32'(dut_v), 32'(e));
        end
        chk("halt_load_data", 32'(rd_data), 32'h123);

        // ---------------- reset during WR_DATA ----------------
        do_reset();
        @(posedge clk);
        #1;
        st_req = 1'b1; st_addr = 10'h111; st_data = 6'h15;
        @(posedge clk);
        #1;
        st_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wrdata_before_reset", 32'(dut_v),
            32'(ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,10'h015)));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_v), 32'(V_IDLE));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            chk($sformatf("post_reset_cyc%0d", cyc), 32'(dut_v), 32'(V_IDLE));
        end

        // ---------------- randomized run vs schedule model ----------------
        begin
            int next_arb, halted_from, m_cnt;
            bit m_halted;
            logic [11:0] m_rd;
            next_arb = 0; halted_from = NRAND + 10; m_cnt = 0; m_halted = 1'b0; m_rd = 12'd0;
            for (int k = 0; k <= NRAND + 3; k++) begin
                exp_sched[k] = V_IDLE;
                cap_sched[k] = 1'b0;
            end
            do_reset();
            for (int c = 0; c < NRAND; c++) begin
                logic [18:0] e;
                bit boost;
                @(posedge clk);
                #1;
                fetch_req = ($urandom_range(0, 2) != 0);
                ld_req = ($urandom_range(0, 2) == 0);
                st_req = ($urandom_range(0, 3) == 0);
                fetch_addr = 10'($urandom_range(0, 1023));
                ld_addr = 10'($urandom_range(0, 1023));
                st_addr = 10'($urandom_range(0, 1023));
                st_data = 6'($urandom_range(0, 63));
                st_upper = 1'($urandom_range(0, 1));
                mem_result = 12'($urandom_range(0, 4095));
                halt_req = halt_req || ((c > 520) && ($urandom_range(0, 29) == 0));
                @(negedge clk);
                e = (c >= halted_from) ? V_HALT : exp_sched[c];
                chk($sformatf("rand_cyc%0d_bus", c), 32'(dut_v), 32'(e));
                chk($sformatf("rand_cyc%0d_rd", c), 32'(rd_data), 32'(m_rd));
                if (cap_sched[c]) m_rd = mem_result;
                if (!m_halted && c >= next_arb) begin
                    boost = STARVE_EN && fetch_req && (m_cnt >= LIMIT);
                    if (halt_req) begin
                        m_halted = 1'b1;
                        halted_from = c + 1;
                    end else if (boost || (fetch_req && !st_req && !ld_req)) begin
                        exp_sched[c+1] = ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,fetch_addr);
                        exp_sched[c+2] = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,fetch_addr);
                        exp_sched[c+3] = ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,10'd0);
                        cap_sched[c+2] = 1'b1;
                        next_arb = c + 3;
                        m_cnt = 0;
                    end else if (st_req) begin
                        exp_sched[c+1] = ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,st_addr);
                        exp_sched[c+2] = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,
                                            {3'b000, st_upper, st_data});
                        exp_sched[c+3] = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,10'd0);
                        next_arb = c + 3;
                        if (fetch_req && m_cnt < 15) m_cnt++;
                    end else if (ld_req) begin
                        exp_sched[c+1] = ev(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,ld_addr);
                        exp_sched[c+2] = ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,ld_addr);
                        exp_sched[c+3] = ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,10'd0);
                        cap_sched[c+2] = 1'b1;
                        next_arb = c + 3;
                        if (fetch_req && m_cnt < 15) m_cnt++;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
